instr_sequencer: RTL
====================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, instruction memory address width and PC width.
REQ-002 SHALL have parameter CNT_W, default 16, retired-instruction counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 start  input  1  begin execution at PC 0; honoured only in IDLE or HALT.
REQ-006 imem_rd_en  output  1  instruction memory read strobe.
REQ-007 imem_addr  output  ADDR_W  instruction memory address.
REQ-008 imem_rdata  input  32  instruction word; valid the cycle after imem_rd_en.
REQ-009 opcode  output  8  instruction [31:24], driven to the control unit.
REQ-010 operand_a  output  8  instruction [23:16], destination register index.
REQ-011 operand_b  output  8  instruction [15:8], source register index.
REQ-012 immediate  output  8  instruction [7:0], immediate, memory address or jump target.
REQ-013 instr_valid  output  1  one-cycle pulse in EXECUTE; control flags are valid in this cycle.
REQ-014 jump_enable  input  1  from the control unit; sampled only in EXECUTE.
REQ-015 finaliza_execucao  input  1  from the control unit; sampled only in EXECUTE.
REQ-016 pc  output  ADDR_W  current program counter.
REQ-017 busy  output  1  high in FETCH, WAIT, DECODE and EXECUTE.
REQ-018 halted  output  1  high in HALT.
REQ-019 instr_count  output  CNT_W  retired instructions since the last start.

Function
REQ-020 FSM states SHALL be IDLE, FETCH, WAIT, DECODE, EXECUTE and HALT; each instruction takes exactly 4 cycles: FETCH, WAIT, DECODE, EXECUTE.
REQ-021 IDLE: start=1 -> FETCH with pc=0 and instr_count=0; otherwise stay in IDLE.
REQ-022 FETCH: imem_rd_en=1 and imem_addr=pc for one cycle; next state WAIT.
REQ-023 WAIT: the instruction register SHALL capture imem_rdata at the end of the cycle; next state DECODE.
REQ-024 DECODE: opcode, operand and immediate fields SHALL come from the instruction register so the registered control unit has them at the DECODE edge; next state EXECUTE.
REQ-025 EXECUTE: instr_valid=1; instr_count increments and saturates at all-ones.
REQ-026 EXECUTE, finaliza_execucao=1: next state HALT; pc unchanged. This takes priority over jump_enable.
REQ-027 EXECUTE, jump_enable=1 and finaliza_execucao=0: pc <= immediate, zero-extended or truncated to ADDR_W; next state FETCH.
REQ-028 EXECUTE, neither flag set: pc <= pc+1 modulo 2^ADDR_W, so all-ones wraps to 0; next state FETCH.
REQ-029 HALT: hold pc, instr_count and the instruction register; start=1 -> FETCH with pc=0 and instr_count=0.
REQ-030 start SHALL be ignored in FETCH, WAIT, DECODE and EXECUTE.
REQ-031 opcode, operand and immediate outputs SHALL stay stable from DECODE until the next WAIT capture.
REQ-032 An invalid opcode, i.e. no flags from the control unit, SHALL advance pc by 1.

Reset
REQ-033 rst=0 at a rising edge SHALL force IDLE from any state, including mid-instruction.
REQ-034 Reset values SHALL be: pc=0, instruction register=0 (so opcode, operand_a, operand_b, immediate=0), imem_rd_en=0, imem_addr=0, instr_valid=0, busy=0, halted=0, instr_count=0.
REQ-035 start asserted together with rst=0 SHALL be ignored.

Verification
REQ-036 Reset, then start; ROM[0]=0x00010005, ROM[1]=0x0F000000 -> imem_addr 0 then 1, instr_valid 4 cycles apart, halted=1 with pc=1 and instr_count=2.
REQ-037 ROM[0]=0x05000007 with jump_enable=1 in EXECUTE -> next fetch at imem_addr=7.
REQ-038 jump_enable=1 and finaliza_execucao=1 in the same EXECUTE -> HALT, pc unchanged, no further fetch.
REQ-039 pc=0xFF with a non-jump instruction -> next fetch at imem_addr=0x00.
REQ-040 rst=0 during WAIT -> next cycle IDLE, all outputs at reset values; start pulse in FETCH -> no effect on pc.
REQ-041 Start from HALT with pc=9 and instr_count=5 -> fetch at imem_addr=0, instr_count=0.

Source files
------------

// File: rtl/instr_sequencer_if.sv
// Bus between the instruction sequencer, its instruction memory and the control unit.
// master = sequencer side, slave = memory / control-unit side.
interface instr_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              imem_rd_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic [7:0]        opcode;
    logic [7:0]        operand_a;
    logic [7:0]        operand_b;
    logic [7:0]        immediate;
    logic              instr_valid;
    logic              jump_enable;
    logic              finaliza_execucao;

    modport master (
        output imem_rd_en, imem_addr,
        output opcode, operand_a, operand_b, immediate, instr_valid,
        input  imem_rdata, jump_enable, finaliza_execucao
    );

    modport slave (
        input  imem_rd_en, imem_addr,
        input  opcode, operand_a, operand_b, immediate, instr_valid,
        output imem_rdata, jump_enable, finaliza_execucao
    );
endinterface

// File: rtl/instr_sequencer.sv
// Four-cycle instruction sequencer: FETCH, WAIT, DECODE, EXECUTE per instruction,
// with jump/halt decisions taken from the control unit during EXECUTE.
module instr_sequencer #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    instr_sequencer_if.master bus,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic [CNT_W-1:0]  instr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DECODE,
        S_EXEC,
        S_HALT
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] instr_reg;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Jump target: zero-extend or truncate the 8-bit immediate to the PC width.
    function automatic logic [ADDR_W-1:0] fit_addr(input logic [7:0] imm);
        logic [ADDR_W+7:0] wide;
        wide = {{ADDR_W{1'b0}}, imm};
        return wide[ADDR_W-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (start) state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_WAIT;
            S_WAIT:   state_nxt = S_DECODE;
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC:   state_nxt = bus.finaliza_execucao ? S_HALT : S_FETCH;
            S_HALT:   if (start) state_nxt = S_FETCH;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.imem_rd_en  = (state == S_FETCH);
        bus.imem_addr   = pc;
        bus.instr_valid = (state == S_EXEC);
        bus.opcode      = instr_reg[31:24];
        bus.operand_a   = instr_reg[23:16];
        bus.operand_b   = instr_reg[15:8];
        bus.immediate   = instr_reg[7:0];
        busy            = (state == S_FETCH) || (state == S_WAIT) ||
                          (state == S_DECODE) || (state == S_EXEC);
        halted          = (state == S_HALT);
    end

    // Halt wins over jump; an instruction raising no flag simply steps the PC.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc          <= '0;
            instr_reg   <= '0;
            instr_count <= '0;
        end else begin
            unique case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        pc          <= '0;
                        instr_count <= '0;
                    end
                end
                S_WAIT: instr_reg <= bus.imem_rdata;
                S_EXEC: begin
                    instr_count <= sat_inc(instr_count);
                    if (!bus.finaliza_execucao) begin
                        pc <= bus.jump_enable ? fit_addr(instr_reg[7:0]) : pc + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
